window_3x3: RTL and testbench

WINDOW_3X3 -- requirements
Module: window_3x3

---
 rtl/window_3x3.sv | 89 ++++++++
 tb/tb_window_3x3.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/window_3x3.sv
// 3x3 sliding-window generator for a raster pixel stream.
// Two cascaded line buffers feed the top rows of a 3x3 shift array; a window
// is flagged valid only when all nine taps belong to the current frame.
module window_3x3 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IMG_W = 8,
  parameter int unsigned IMG_H = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     pix_in,
  input  logic                 pix_valid,
  output logic [9*WIDTH-1:0]   win_out,
  output logic                 win_valid,
  output logic                 frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [WIDTH-1:0]       buf_a [IMG_W];
  logic [WIDTH-1:0]       buf_b [IMG_W];
  logic [WIDTH-1:0]       tap_a_c;
  logic [WIDTH-1:0]       tap_b_c;
  logic                   col_last_c;
  logic                   row_last_c;
  logic [8:0][WIDTH-1:0]  win;

  // Line buffer taps: slot[col] was written exactly IMG_W accepted pixels ago.
  assign tap_a_c    = buf_a[col];
  assign tap_b_c    = buf_b[col];
  assign col_last_c = (col == CW'(IMG_W - 1));
  assign row_last_c = (row == RW'(IMG_H - 1));
  assign win_out    = win;

  // Cascaded line buffers; contents are never exposed until fully refilled.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      buf_a[col] <= pix_in;
      buf_b[col] <= tap_a_c;
    end
  end

  // Raster position of the pixel being accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else if (pix_valid) begin
      if (col_last_c) begin
        col <= '0;
        row <= row_last_c ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // 3x3 shift array: each row shifts toward column 0, new column on the right.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win <= '0;
    end else if (pix_valid) begin
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= tap_b_c;
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= tap_a_c;
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= pix_in;
    end
  end

  // Window qualifiers: valid only once two rows and two columns are in place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= pix_valid && (row >= RW'(2)) && (col >= CW'(2));
      frame_done <= pix_valid && row_last_c && col_last_c;
    end
  end

endmodule

// File: tb/tb_window_3x3.sv
// Directed bench for window_3x3: 4x4 frames plus a 3x5 parameter variant.
module tb_window_3x3;

  logic        clk;
  logic        reset_n;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic [71:0] win_out;
  logic        win_valid;
  logic        frame_done;

  logic [7:0]  pix_b;
  logic        valid_b;
  logic [71:0] win_b;
  logic        wv_b;
  logic        fd_b;

  int checks;
  int errors;
  int nwin;
  int nfd;

  typedef struct {
    logic [7:0]  pix;
    logic        wv;
    logic        fd;
    logic [71:0] win;
  } vec_t;

  vec_t tbl [16];

  window_3x3 #(.WIDTH(8), .IMG_W(4), .IMG_H(4)) u_a (
    .clk(clk), .reset_n(reset_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .win_out(win_out), .win_valid(win_valid), .frame_done(frame_done)
  );

  window_3x3 #(.WIDTH(8), .IMG_W(3), .IMG_H(5)) u_b (
    .clk(clk), .reset_n(reset_n), .pix_in(pix_b), .pix_valid(valid_b),
    .win_out(win_b), .win_valid(wv_b), .frame_done(fd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] pk(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5,
                                     input int a6, input int a7, input int a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [7:0] p);
    @(negedge clk);
    pix_valid = v;
    pix_in    = p;
    @(posedge clk);
    #1;
    if (win_valid)  nwin++;
    if (frame_done) nfd++;
  endtask

  task automatic step_b(input logic v, input logic [7:0] p);
    @(negedge clk);
    valid_b = v;
    pix_b   = p;
    @(posedge clk);
    #1;
  endtask

  // Plays one 4x4 frame from the table with an offset on every pixel value.
  task automatic run_frame(input int ofs, input logic bubble, input string tag);
    logic [71:0] ofs72;
    ofs72 = {9{8'(ofs)}};
    for (int i = 0; i < 16; i++) begin
      if (bubble) begin
        step(1'b0, 8'hEE);
        chk({tag, "_bub_wv"}, 72'(win_valid), 72'(1'b0));
        chk({tag, "_bub_fd"}, 72'(frame_done), 72'(1'b0));
        if (i > 0 && tbl[i-1].wv)
          chk({tag, "_bub_hold"}, win_out, tbl[i-1].win + ofs72);
      end
      step(1'b1, tbl[i].pix + 8'(ofs));
      chk($sformatf("%s_wv_%0d", tag, i), 72'(win_valid), 72'(tbl[i].wv));
      chk($sformatf("%s_fd_%0d", tag, i), 72'(frame_done), 72'(tbl[i].fd));
      if (tbl[i].wv)
        chk($sformatf("%s_win_%0d", tag, i), win_out, tbl[i].win + ofs72);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    nwin      = 0;
    nfd       = 0;
    reset_n   = 1'b0;
    pix_valid = 1'b0;
    pix_in    = '0;
    valid_b   = 1'b0;
    pix_b     = '0;

    for (int i = 0; i < 16; i++) begin
      tbl[i].pix = 8'(i);
      tbl[i].wv  = 1'b0;
      tbl[i].fd  = 1'b0;
      tbl[i].win = '0;
    end
    tbl[10].wv = 1'b1; tbl[10].win = pk(0, 1, 2, 4, 5, 6, 8, 9, 10);
    tbl[11].wv = 1'b1; tbl[11].win = pk(1, 2, 3, 5, 6, 7, 9, 10, 11);
    tbl[14].wv = 1'b1; tbl[14].win = pk(4, 5, 6, 8, 9, 10, 12, 13, 14);
    tbl[15].wv = 1'b1; tbl[15].win = pk(5, 6, 7, 9, 10, 11, 13, 14, 15);
    tbl[15].fd = 1'b1;

    // Reset state
    #12;
    chk("rst_wv", 72'(win_valid), 72'(1'b0));
    chk("rst_fd", 72'(frame_done), 72'(1'b0));
    chk("rst_win", win_out, 72'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Continuous frame
    nwin = 0; nfd = 0;
    run_frame(0, 1'b0, "cont");
    chk("cont_nwin", 72'(nwin), 72'(4));
    chk("cont_nfd", 72'(nfd), 72'(1));
    step(1'b0, 8'h00);
    chk("cont_fd_once", 72'(frame_done), 72'(1'b0));

    // Bubble frame: every other cycle idle
    nwin = 0; nfd = 0;
    run_frame(0, 1'b1, "bub");
    chk("bub_nwin", 72'(nwin), 72'(4));
    chk("bub_nfd", 72'(nfd), 72'(1));

    // Reset mid-frame after pixel 9
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i));
    pix_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wv", 72'(win_valid), 72'(1'b0));
    chk("mid_rst_fd", 72'(frame_done), 72'(1'b0));
    chk("mid_rst_win", win_out, 72'(0));
    @(negedge clk);
    reset_n = 1'b1;
    nwin = 0; nfd = 0;
    run_frame(0, 1'b0, "rstart");
    chk("rstart_nwin", 72'(nwin), 72'(4));

    // Two frames back to back, second offset by 100
    nwin = 0; nfd = 0;
    run_frame(0, 1'b0, "seq1");
    run_frame(100, 1'b0, "seq2");
    chk("seq_nwin", 72'(nwin), 72'(8));
    chk("seq_nfd", 72'(nfd), 72'(2));
    step(1'b0, 8'h00);

    // Fifth window of the sequence, replayed explicitly
    for (int i = 0; i < 11; i++) step(1'b1, 8'(100 + i));
    chk("seq_win5", win_out, pk(100, 101, 102, 104, 105, 106, 108, 109, 110));
    for (int i = 11; i < 16; i++) step(1'b1, 8'(100 + i));
    step(1'b0, 8'h00);

    // 3x5 variant: windows after pixels 8, 11, 14
    for (int i = 0; i < 15; i++) begin
      step_b(1'b1, 8'(i));
      chk($sformatf("b_wv_%0d", i), 72'(wv_b), 72'(i == 8 || i == 11 || i == 14));
      chk($sformatf("b_fd_%0d", i), 72'(fd_b), 72'(i == 14));
      if (i == 8)  chk("b_win_8",  win_b, pk(0, 1, 2, 3, 4, 5, 6, 7, 8));
      if (i == 11) chk("b_win_11", win_b, pk(3, 4, 5, 6, 7, 8, 9, 10, 11));
      if (i == 14) chk("b_win_14", win_b, pk(6, 7, 8, 9, 10, 11, 12, 13, 14));
    end
    step_b(1'b0, 8'h00);
    chk("b_idle_wv", 72'(wv_b), 72'(1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
